// File: rtl/ram_bist_ctrl.sv
// March C- style BIST initiator for a single-port synchronous RAM with one-cycle read latency.
// Reports pass/fail and the first failing address; RAM ports are only driven while busy_o.
module ram_bist_ctrl #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 128,
  parameter int unsigned Aw      = $clog2(Depth),
  parameter logic [31:0] Pattern = 32'h5555_5555
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [Aw-1:0]    err_addr_o,
  output logic             req_o,
  output logic             write_o,
  output logic [Aw-1:0]    addr_o,
  output logic [Width-1:0] wdata_o,
  input  logic             rvalid_i,
  input  logic [Width-1:0] rdata_i
);

  localparam logic [Width-1:0] Pat      = Width'(Pattern);
  localparam logic [Aw-1:0]    LastAddr = Aw'(Depth - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR0,
    S_RDA,
    S_WRA,
    S_RDB,
    S_WRB,
    S_RDC,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [Aw-1:0]     pend_addr_q, pend_addr_d;
  logic              pass_q, pass_d;
  logic [Aw-1:0]     err_addr_q, err_addr_d;

  logic              cmp_en;
  logic [Aw-1:0]     cmp_addr;
  logic [Width-1:0]  cmp_exp;
  logic              mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pass_q      <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pass_q      <= pass_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pass_d      = pass_q;
    err_addr_d  = err_addr_q;
    req_o       = 1'b0;
    write_o     = 1'b0;
    addr_o      = '0;
    wdata_o     = '0;
    cmp_en      = 1'b0;
    cmp_addr    = addr_q;
    cmp_exp     = Pat;
    busy_o      = (state_q != S_IDLE) && (state_q != S_FIN);
    done_o      = (state_q == S_FIN);

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start_i) begin
          state_d    = S_WR0;
          addr_d     = '0;
          pass_d     = 1'b0;
          err_addr_d = '0;
        end
      end
      S_WR0: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = addr_q;
        wdata_o = Pat;
        if (addr_q == LastAddr) begin
          state_d = S_RDA;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + Aw'(1);
        end
      end
      S_RDA: begin
        req_o   = 1'b1;
        addr_o  = addr_q;
        state_d = S_WRA;
      end
      // The write-back is decoded from state alone, so it also goes out in a failing compare cycle.
      S_WRA: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = addr_q;
        wdata_o = ~Pat;
        cmp_en  = 1'b1;
        cmp_exp = Pat;
        if (addr_q == LastAddr) begin
          state_d = S_RDB;
        end else begin
          state_d = S_RDA;
          addr_d  = addr_q + Aw'(1);
        end
      end
      S_RDB: begin
        req_o   = 1'b1;
        addr_o  = addr_q;
        state_d = S_WRB;
      end
      S_WRB: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = addr_q;
        wdata_o = Pat;
        cmp_en  = 1'b1;
        cmp_exp = ~Pat;
        if (addr_q == '0) begin
          state_d = S_RDC;
        end else begin
          state_d = S_RDB;
          addr_d  = addr_q - Aw'(1);
        end
      end
      // Pipelined reads: each cycle compares the read issued one cycle earlier.
      S_RDC: begin
        req_o       = 1'b1;
        addr_o      = addr_q;
        pend_d      = 1'b1;
        pend_addr_d = addr_q;
        cmp_en      = pend_q;
        cmp_addr    = pend_addr_q;
        if (addr_q == LastAddr) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + Aw'(1);
        end
      end
      S_DRAIN: begin
        cmp_en   = 1'b1;
        cmp_addr = pend_addr_q;
        state_d  = S_FIN;
        pass_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    mismatch = cmp_en && (!rvalid_i || (rdata_i != cmp_exp));
    if (mismatch) begin
      state_d    = S_FIN;
      pass_d     = 1'b0;
      err_addr_d = cmp_addr;
    end
  end

  assign pass_o     = pass_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faulty-RAM environment plus a march-level reference that
// predicts the request trace, completion cycle and verdict of each run.
module tb_ram_bist_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned D   = 16;
  localparam int unsigned AW  = $clog2(D);
  localparam logic [31:0] P   = 32'h5555_5555;
  localparam int          LIM = 6 * D + 8;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, pass_o, req_o, write_o;
  logic [AW-1:0] err_addr_o, addr_o;
  logic [W-1:0]  wdata_o;
  logic          rvalid_i = 1'b0;
  logic [W-1:0]  rdata_i  = '0;

  int checks = 0;
  int errors = 0;

  // fault kinds: 0 none, 1 stuck bit, 2 write alias f_addr -> f_addr2, 3 drop rvalid of read #drop_idx
  int   fault_kind = 0;
  int   f_addr     = 0;
  int   f_addr2    = 1;
  int   f_bit      = 0;
  bit   f_val      = 1'b0;
  int   drop_idx   = 0;
  bit   env_clr    = 1'b0;
  logic [W-1:0] env_mem [D];
  int   env_rd = 0;

  ram_bist_ctrl #(
    .Width  (W),
    .Depth  (D),
    .Pattern(P)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .err_addr_o(err_addr_o),
    .req_o     (req_o),
    .write_o   (write_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .rvalid_i  (rvalid_i),
    .rdata_i   (rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] cell_read(logic [W-1:0] stored, int a);
    logic [W-1:0] v;
    v = stored;
    if (fault_kind == 1 && a == f_addr) v[f_bit] = f_val;
    return v;
  endfunction

  // RAM environment with planted faults
  always @(posedge clk_i) begin
    rvalid_i <= 1'b0;
    if (env_clr) env_rd <= 0;
    if (req_o && write_o) begin
      env_mem[addr_o] <= wdata_o;
      if (fault_kind == 2 && int'(addr_o) == f_addr) env_mem[f_addr2] <= wdata_o;
    end else if (req_o) begin
      rdata_i  <= cell_read(env_mem[addr_o], int'(addr_o));
      rvalid_i <= !(fault_kind == 3 && env_rd == drop_idx);
      if (!env_clr) env_rd <= env_rd + 1;
    end
  end

  // reference model: march elements replayed on a plain array, timed one op per cycle
  bit           ref_req  [LIM+1];
  bit           ref_wr   [LIM+1];
  int           ref_addr [LIM+1];
  logic [W-1:0] ref_wd   [LIM+1];
  logic [W-1:0] rmem [D];
  int  rrd;
  bit  ref_pass;
  int  ref_err, ref_done, ref_nreq;

  task automatic issue(int t, bit w, int a, logic [W-1:0] d);
    ref_req[t]  = 1'b1;
    ref_wr[t]   = w;
    ref_addr[t] = a;
    ref_wd[t]   = w ? d : '0;
    ref_nreq++;
  endtask

  task automatic mwrite(int a, logic [W-1:0] d);
    rmem[a] = d;
    if (fault_kind == 2 && a == f_addr) rmem[f_addr2] = d;
  endtask

  task automatic mread(int a, output bit ok_v, output logic [W-1:0] d);
    d    = cell_read(rmem[a], a);
    ok_v = !(fault_kind == 3 && rrd == drop_idx);
    rrd++;
  endtask

  task automatic build_ref();
    int t;
    int f;
    bit v;
    logic [W-1:0] d;
    for (int i = 0; i <= LIM; i++) begin
      ref_req[i] = 1'b0; ref_wr[i] = 1'b0; ref_addr[i] = 0; ref_wd[i] = '0;
    end
    ref_nreq = 0; rrd = 0; ref_pass = 1'b1; ref_err = 0; ref_done = 6 * D + 2;
    t = 1;
    for (int n = 0; n < D; n++) begin
      issue(t, 1'b1, n, P); mwrite(n, P); t++;
    end
    for (int n = 0; n < D; n++) begin
      issue(t, 1'b0, n, '0); mread(n, v, d); t++;
      issue(t, 1'b1, n, ~P); mwrite(n, ~P);
      if (!v || d != P) begin ref_pass = 1'b0; ref_err = n; ref_done = t + 1; return; end
      t++;
    end
    for (int k = 0; k < D; k++) begin
      int n;
      n = D - 1 - k;
      issue(t, 1'b0, n, '0); mread(n, v, d); t++;
      issue(t, 1'b1, n, P); mwrite(n, P);
      if (!v || d != ~P) begin ref_pass = 1'b0; ref_err = n; ref_done = t + 1; return; end
      t++;
    end
    f = -1;
    for (int n = 0; n < D; n++) begin
      mread(n, v, d);
      if (f < 0 && (!v || d != P)) f = n;
    end
    for (int n = 0; n < D; n++)
      if (f < 0 || n <= f + 1) issue(t + n, 1'b0, n, '0);
    if (f >= 0) begin ref_pass = 1'b0; ref_err = f; ref_done = t + f + 2; end
  endtask

  task automatic run_test(input string name, input bit use_tab, input bit exp_pass,
                          input int exp_err, input int exp_done, input int exp_nreq,
                          input bit spam, input int rst_at);
    int nreq = 0;
    int first_done = -1;
    build_ref();
    env_clr = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    env_clr = 1'b0;
    for (int k = 1; k <= LIM; k++) begin
      bit dn;
      dn = (k >= ref_done);
      checks++;
      if (req_o !== ref_req[k] ||
          (ref_req[k] && (write_o !== ref_wr[k] || addr_o !== AW'(ref_addr[k]) ||
                          (ref_wr[k] && wdata_o !== ref_wd[k])))) begin
        errors++;
        $display("FAIL %s bus cycle %0d: got req=%0b wr=%0b addr=%0d wdata=%h, want req=%0b wr=%0b addr=%0d wdata=%h",
                 name, k, req_o, write_o, addr_o, wdata_o, ref_req[k], ref_wr[k], ref_addr[k], ref_wd[k]);
      end
      checks++;
      if (done_o !== dn || busy_o !== !dn || pass_o !== (dn && ref_pass) ||
          err_addr_o !== AW'((dn && !ref_pass) ? ref_err : 0)) begin
        errors++;
        $display("FAIL %s status cycle %0d: got busy=%0b done=%0b pass=%0b err=%0d, want busy=%0b done=%0b pass=%0b err=%0d",
                 name, k, busy_o, done_o, pass_o, err_addr_o, !dn, dn, dn && ref_pass,
                 (dn && !ref_pass) ? ref_err : 0);
      end
      if (req_o) nreq++;
      if (done_o && first_done < 0) first_done = k;
      if (k == rst_at) begin
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, pass_o, req_o, write_o} !== 5'b0 || err_addr_o !== '0 ||
            addr_o !== '0 || wdata_o !== '0) begin
          errors++;
          $display("FAIL %s reset_outputs: got busy=%0b done=%0b pass=%0b req=%0b wr=%0b err=%0d addr=%0d wdata=%h, want all 0",
                   name, busy_o, done_o, pass_o, req_o, write_o, err_addr_o, addr_o, wdata_o);
        end
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s reset_hold: got req=%0b busy=%0b, want 0 0", name, req_o, busy_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        return;
      end
      start_i = spam && (k == 10 || k == 40 || k == 97);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    checks++;
    if (nreq != (use_tab ? exp_nreq : ref_nreq)) begin
      errors++;
      $display("FAIL %s req_count: got %0d, want %0d", name, nreq, use_tab ? exp_nreq : ref_nreq);
    end
    if (use_tab) begin
      checks++;
      if (first_done != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d, want %0d", name, first_done, exp_done);
      end
      checks++;
      if (pass_o !== exp_pass || done_o !== 1'b1) begin
        errors++;
        $display("FAIL %s verdict: got done=%0b pass=%0b, want done=1 pass=%0b", name, done_o, pass_o, exp_pass);
      end
      checks++;
      if (err_addr_o !== AW'(exp_err)) begin
        errors++;
        $display("FAIL %s err_addr: got %0d, want %0d", name, err_addr_o, exp_err);
      end
    end
  endtask

  typedef struct {
    string name;
    int    kind;
    int    a;
    int    a2;
    int    bitn;
    bit    val;
    int    drop;
    bit    spam;
    int    rst_at;
    bit    exp_pass;
    int    exp_err;
    int    exp_done;
    int    exp_nreq;
  } vec_t;

  vec_t tab [7];

  initial begin
    //          name         kind a  a2 bit val drop     spam rst pass err done nreq
    tab[0] = '{"clean",      0,   0, 1, 0,  0,  0,       0,   0,  1,   0,  98,  96};
    tab[1] = '{"stuck5b3",   1,   5, 1, 3,  0,  0,       0,   0,  0,   5,  71,  70};
    tab[2] = '{"alias9to1",  2,   9, 1, 0,  0,  0,       0,   0,  0,   1,  79,  78};
    tab[3] = '{"drop_rdc15", 3,   0, 1, 0,  0,  2*D+15,  0,   0,  0,   15, 98,  96};
    tab[4] = '{"start_spam", 0,   0, 1, 0,  0,  0,       1,   0,  1,   0,  98,  96};
    tab[5] = '{"reset40",    0,   0, 1, 0,  0,  0,       0,   40, 0,   0,  0,   0};
    tab[6] = '{"after_rst",  0,   0, 1, 0,  0,  0,       0,   0,  1,   0,  98,  96};

    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, pass_o, req_o, write_o} !== 5'b0 || err_addr_o !== '0 ||
        addr_o !== '0 || wdata_o !== '0) begin
      errors++;
      $display("FAIL por_reset: got busy=%0b done=%0b pass=%0b req=%0b wr=%0b err=%0d, want all 0",
               busy_o, done_o, pass_o, req_o, write_o, err_addr_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      fault_kind = tab[i].kind;
      f_addr     = tab[i].a;
      f_addr2    = tab[i].a2;
      f_bit      = tab[i].bitn;
      f_val      = tab[i].val;
      drop_idx   = tab[i].drop;
      run_test(tab[i].name, tab[i].rst_at == 0, tab[i].exp_pass, tab[i].exp_err,
               tab[i].exp_done, tab[i].exp_nreq, tab[i].spam, tab[i].rst_at);
    end

    for (int r = 0; r < 24; r++) begin
      fault_kind = int'($urandom_range(0, 3));
      f_addr     = int'($urandom_range(0, D - 1));
      f_addr2    = (f_addr + int'($urandom_range(1, D - 1))) % D;
      f_bit      = int'($urandom_range(0, W - 1));
      f_val      = 1'($urandom_range(0, 1));
      drop_idx   = int'($urandom_range(0, 3 * D - 1));
      run_test($sformatf("rand%0d_k%0d", r, fault_kind), 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
